// File: rtl/dram_arb.sv
//------------------------------------------------------------------------------
// Module  : dram_arb
// Brief   : Shares one DRAM sequencer between CPU, DMA and a CBR refresh
//           scheduler with a deferrable refresh backlog and a WAIT watchdog.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dram_arb #(
    parameter int REF_INTERVAL = 500,
    parameter int REF_MAX_PEND = 4,
    parameter int SEQ_TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       RESET,
    input  logic       cpu_req,
    output logic       cpu_gnt,
    output logic       cpu_done,
    input  logic       dma_req,
    output logic       dma_gnt,
    output logic       dma_done,
    output logic       seq_start,
    output logic [1:0] seq_op,
    input  logic       seq_done,
    output logic [2:0] ref_pend,
    output logic       ref_overflow,
    output logic       seq_timeout
);

    localparam logic [1:0] c_OP_CPU   = 2'b00;
    localparam logic [1:0] c_OP_DMA   = 2'b01;
    localparam logic [1:0] c_OP_REF   = 2'b10;
    localparam logic [8:0] c_Q_LAST   = 9'(REF_INTERVAL - 1);
    localparam logic [2:0] c_PEND_MAX = 3'(REF_MAX_PEND);
    localparam int         c_WD_W     = $clog2(SEQ_TIMEOUT) + 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(SEQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [1:0]          w_op_nxt;
    logic                r_last_dma;
    logic                w_last_dma_nxt;
    logic [c_WD_W-1:0]   r_wd;
    logic [c_WD_W-1:0]   w_wd_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;

    logic [8:0]          r_q;
    logic [2:0]          r_pend;
    logic                r_ovf;
    logic                w_tick;
    logic                w_ref_issue;
    logic                w_busy;

    // Arbitration runs only in IDLE; owner/op are latched on the way to ISSUE.
    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_last_dma_nxt = r_last_dma;
        w_wd_nxt       = r_wd;
        w_timeout_nxt  = r_timeout;
        case (r_state)
            S_IDLE: begin
                w_wd_nxt = '0;
                if (r_pend == c_PEND_MAX) begin
                    w_op_nxt    = c_OP_REF;
                    w_state_nxt = S_ISSUE;
                end else if (cpu_req && (!dma_req || r_last_dma)) begin
                    w_op_nxt       = c_OP_CPU;
                    w_last_dma_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end else if (dma_req) begin
                    w_op_nxt       = c_OP_DMA;
                    w_last_dma_nxt = 1'b1;
                    w_state_nxt    = S_ISSUE;
                end else if (r_pend != 3'd0) begin
                    w_op_nxt    = c_OP_REF;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (seq_done) begin
                    w_state_nxt = S_DONE;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_wd_nxt = r_wd + 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Falling-edge registers, in step with the DRAM sequencer.
    always_ff @(negedge clk) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_op       <= c_OP_CPU;
            r_last_dma <= 1'b1;
            r_wd       <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_last_dma <= w_last_dma_nxt;
            r_wd       <= w_wd_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    assign w_tick      = (r_q == c_Q_LAST);
    assign w_ref_issue = (r_state == S_ISSUE) && (r_op == c_OP_REF);

    // A tick and a refresh issue in the same cycle cancel out.
    always_ff @(negedge clk) begin
        if (RESET) begin
            r_q    <= '0;
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_q <= w_tick ? 9'd0 : r_q + 9'd1;
            if (w_tick && !w_ref_issue) begin
                if (r_pend == c_PEND_MAX) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_pend <= r_pend + 3'd1;
                end
            end else if (!w_tick && w_ref_issue) begin
                r_pend <= r_pend - 3'd1;
            end
        end
    end

    assign w_busy       = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign cpu_gnt      = w_busy && (r_op == c_OP_CPU);
    assign dma_gnt      = w_busy && (r_op == c_OP_DMA);
    assign cpu_done     = (r_state == S_DONE) && (r_op == c_OP_CPU);
    assign dma_done     = (r_state == S_DONE) && (r_op == c_OP_DMA);
    assign seq_start    = (r_state == S_ISSUE);
    assign seq_op       = (r_state == S_IDLE) ? c_OP_CPU : r_op;
    assign ref_pend     = r_pend;
    assign ref_overflow = r_ovf;
    assign seq_timeout  = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_dram_arb.sv
//------------------------------------------------------------------------------
// Module  : tb_dram_arb
// Brief   : Scoreboard bench for dram_arb with a fixed-latency sequencer model.
// Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dram_arb;

    localparam int         c_REF    = 500;
    localparam int         c_LAT    = 3;
    localparam logic [1:0] c_OP_CPU = 2'b00;
    localparam logic [1:0] c_OP_DMA = 2'b01;
    localparam logic [1:0] c_OP_REF = 2'b10;

    logic       clk = 1'b0;
    logic       RESET, cpu_req, dma_req, seq_done;
    logic       cpu_gnt, cpu_done, dma_gnt, dma_done, seq_start;
    logic       ref_overflow, seq_timeout;
    logic [1:0] seq_op;
    logic [2:0] ref_pend;

    logic       b_cpu_req;
    logic       b_cpu_gnt, b_cpu_done, b_dma_gnt, b_dma_done, b_seq_start;
    logic       b_ref_overflow, b_seq_timeout;
    logic [1:0] b_seq_op;
    logic [2:0] b_ref_pend;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc, seq_cnt, n_start, ndone, t0, ref_cyc;
    bit         hold, sb_on;
    logic [1:0] exp_q[$];
    int         start_cyc[$];

    always #15 clk = ~clk;

    dram_arb u_dut (
        .clk(clk), .RESET(RESET),
        .cpu_req(cpu_req), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done),
        .dma_req(dma_req), .dma_gnt(dma_gnt), .dma_done(dma_done),
        .seq_start(seq_start), .seq_op(seq_op), .seq_done(seq_done),
        .ref_pend(ref_pend), .ref_overflow(ref_overflow), .seq_timeout(seq_timeout)
    );

    // Long watchdog so a refresh can be stuck across several ticks.
    dram_arb #(.REF_INTERVAL(500), .REF_MAX_PEND(4), .SEQ_TIMEOUT(1024)) u_dut_b (
        .clk(clk), .RESET(RESET),
        .cpu_req(b_cpu_req), .cpu_gnt(b_cpu_gnt), .cpu_done(b_cpu_done),
        .dma_req(1'b0), .dma_gnt(b_dma_gnt), .dma_done(b_dma_done),
        .seq_start(b_seq_start), .seq_op(b_seq_op), .seq_done(1'b0),
        .ref_pend(b_ref_pend), .ref_overflow(b_ref_overflow), .seq_timeout(b_seq_timeout)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One cycle: DUT updates on negedge, bench samples and drives on posedge.
    task automatic step();
        @(posedge clk);
        cyc++;
        seq_done = 1'b0;
        chk_eq("one_gnt", 32'(cpu_gnt & dma_gnt), 32'd0);
        if (seq_start) begin
            n_start++;
            start_cyc.push_back(cyc);
            if (sb_on) begin
                chk_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk_eq("sb_op", 32'(seq_op), 32'(exp_q.pop_front()));
            end
            if (!hold) seq_cnt = c_LAT;
        end else if (seq_cnt > 0) begin
            seq_cnt--;
            if (seq_cnt == 0) seq_done = 1'b1;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
        cyc = 0; seq_cnt = 0; n_start = 0;
        exp_q.delete();
        start_cyc.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: observed running, expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        RESET = 1'b1; cpu_req = 1'b0; dma_req = 1'b0; seq_done = 1'b0;
        b_cpu_req = 1'b0; hold = 1'b0; sb_on = 1'b0;
        cyc = 0; seq_cnt = 0; n_start = 0;

        do_reset();
        chk_eq("rst_outs", 32'({cpu_gnt, cpu_done, dma_gnt, dma_done, seq_start,
                                ref_overflow, seq_timeout}), 32'd0);
        chk_eq("rst_op", 32'(seq_op), 32'd0);
        chk_eq("rst_pend", 32'(ref_pend), 32'd0);

        // Idle: three opportunistic refreshes
        sb_on = 1'b1;
        repeat (3) exp_q.push_back(c_OP_REF);
        for (int i = 1; i < 4 * c_REF; i++) begin
            step();
            if (cyc == c_REF - 1) chk_eq("idle_pend_pre", 32'(ref_pend), 32'd0);
            if (cyc == c_REF)     chk_eq("idle_pend_tick", 32'(ref_pend), 32'd1);
        end
        chk_eq("idle_nstart", 32'(start_cyc.size()), 32'd3);
        for (int i = 0; i < start_cyc.size() && i < 3; i++)
            chk_eq("idle_start_cyc", 32'(start_cyc[i]), 32'((i + 1) * c_REF + 1));
        chk_eq("idle_pend_end", 32'(ref_pend), 32'd0);
        chk_eq("idle_sb_left", 32'(exp_q.size()), 32'd0);

        // Watchdog path, then a normal CPU access
        sb_on = 1'b0; do_reset(); sb_on = 1'b1;
        hold = 1'b1; cpu_req = 1'b1;
        exp_q.push_back(c_OP_CPU); exp_q.push_back(c_OP_CPU);
        for (int i = 0; i < 10 && n_start == 0; i++) step();
        chk_eq("to_started", 32'(n_start), 32'd1);
        chk_eq("to_gnt", 32'(cpu_gnt), 32'd1);
        t0 = cyc;
        for (int i = 0; i < 200; i++) begin
            step();
            if (cyc == t0 + 64) chk_eq("to_early", 32'(seq_timeout), 32'd0);
            if (cpu_done) break;
        end
        chk_eq("to_done", 32'(cpu_done), 32'd1);
        chk_eq("to_len", 32'(cyc - t0), 32'd65);
        chk_eq("to_flag", 32'(seq_timeout), 32'd1);
        chk_eq("to_gnt_done", 32'(cpu_gnt), 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cpu_done) break;
        end
        cpu_req = 1'b0;
        chk_eq("to_next_done", 32'(cpu_done), 32'd1);
        chk_eq("to_nstart", 32'(n_start), 32'd2);
        chk_eq("to_sticky", 32'(seq_timeout), 32'd1);

        // CPU and DMA contending: strict alternation starting with CPU
        sb_on = 1'b0; do_reset(); sb_on = 1'b1;
        repeat (3) begin
            exp_q.push_back(c_OP_CPU);
            exp_q.push_back(c_OP_DMA);
        end
        ndone = 0;
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int i = 0; i < 300 && ndone < 6; i++) begin
            step();
            cpu_req = 1'b1; dma_req = 1'b1;
            if (cpu_done) begin cpu_req = 1'b0; ndone++; end
            if (dma_done) begin dma_req = 1'b0; ndone++; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        repeat (10) step();
        chk_eq("rr_ndone", 32'(ndone), 32'd6);
        chk_eq("rr_sb_left", 32'(exp_q.size()), 32'd0);

        // Saturating CPU traffic: backlog forces refresh at four
        sb_on = 1'b0; do_reset();
        cpu_req = 1'b1; ref_cyc = -1;
        for (int i = 0; i < 5 * c_REF + 10; i++) begin
            step();
            if (cyc == 4 * c_REF - 1) chk_eq("bl_pend3", 32'(ref_pend), 32'd3);
            if (cyc == 4 * c_REF)     chk_eq("bl_pend4", 32'(ref_pend), 32'd4);
            if (cyc == 5 * c_REF)     chk_eq("bl_pend_5th", 32'(ref_pend), 32'd4);
            if (seq_start && seq_op == c_OP_REF && ref_cyc < 0) ref_cyc = cyc;
        end
        cpu_req = 1'b0;
        chk_eq("bl_ref_window", 32'(ref_cyc > 4 * c_REF && ref_cyc <= 4 * c_REF + 8), 32'd1);
        chk_eq("bl_no_ovf", 32'(ref_overflow), 32'd0);

        // Overflow on the long-watchdog instance: refresh stuck across two ticks
        b_cpu_req = 1'b1;
        do_reset();
        for (int i = 0; i < 3050; i++) begin
            step();
            if (cyc == 2055) chk_eq("ov_ref_issue", 32'(b_seq_start && b_seq_op == c_OP_REF), 32'd1);
            if (cyc == 2056) chk_eq("ov_pend_dec", 32'(b_ref_pend), 32'd3);
            if (cyc == 2999) chk_eq("ov_pre", 32'({b_ref_overflow, b_ref_pend}), 32'd4);
            if (cyc == 3000) chk_eq("ov_set", 32'({b_ref_overflow, b_ref_pend}), 32'd12);
        end
        chk_eq("ov_sticky", 32'({b_ref_overflow, b_ref_pend}), 32'd12);
        b_cpu_req = 1'b0;

        // RESET in the middle of a DMA access
        do_reset();
        dma_req = 1'b1;
        while (cyc < c_REF + 20) step();
        chk_eq("mr_pend_before", 32'(ref_pend), 32'd1);
        hold = 1'b1;
        n_start = 0;
        for (int i = 0; i < 20 && n_start == 0; i++) step();
        chk_eq("mr_dma_start", 32'(seq_op), 32'(c_OP_DMA));
        repeat (3) step();
        chk_eq("mr_gnt_wait", 32'(dma_gnt), 32'd1);
        RESET = 1'b1;
        step();
        chk_eq("mr_after", 32'({dma_gnt, dma_done, seq_start, seq_op, ref_pend}), 32'd0);
        RESET = 1'b0; dma_req = 1'b0; cyc = 0; ndone = 0;
        for (int i = 0; i < c_REF; i++) begin
            step();
            if (dma_done) ndone++;
            if (cyc == c_REF - 1) chk_eq("mr_q_pre", 32'(ref_pend), 32'd0);
            if (cyc == c_REF)     chk_eq("mr_q_tick", 32'(ref_pend), 32'd1);
        end
        chk_eq("mr_no_done", 32'(ndone), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dram_arb.md
Name: dram_arb

Overview:
- Arbiter/scheduler in front of the DRAM sequencer state machine.
- Shares the single DRAM sequencer between three requesters: the 68040 CPU port, a secondary DMA port, and an internal CBR refresh scheduler.
- Issues exactly one access command at a time and waits for its completion.
- Owns the refresh interval timer and a pending-refresh backlog, so refreshes can be deferred behind CPU/DMA traffic up to a limit.

Parameters:
- REF_INTERVAL, 500, clk cycles between refresh ticks (500 × 30.303 ns = 15.15 µs at 33 MHz).
- REF_MAX_PEND, 4, maximum deferred refreshes; backlog at this value forces refresh priority.
- SEQ_TIMEOUT, 64, maximum cycles in WAIT for seq_done before abort.

Ports:
- clk  in  1  system clock; all registers update on falling edge, matching the DRAM sequencer.
- RESET  in  1  reset, synchronous, active-high.
- cpu_req  in  1  CPU access request, level.
- cpu_gnt  out  1  CPU owns the sequencer.
- cpu_done  out  1  one-cycle pulse, CPU access complete.
- dma_req  in  1  DMA access request, level.
- dma_gnt  out  1  DMA owns the sequencer.
- dma_done  out  1  one-cycle pulse, DMA access complete.
- seq_start  out  1  one-cycle command strobe to the sequencer.
- seq_op  out  2  00 = CPU r/w, 01 = DMA r/w, 10 = CBR refresh, 11 = unused; valid while not IDLE.
- seq_done  in  1  one-cycle pulse from the sequencer, access finished.
- ref_pend  out  3  current refresh backlog, 0..REF_MAX_PEND.
- ref_overflow  out  1  sticky; a refresh tick was lost because the backlog was full.
- seq_timeout  out  1  sticky; SEQ_TIMEOUT expired in WAIT.

Behaviour:
Reset (synchronous, RESET = 1 at a falling edge):
- state = IDLE; all outputs 0; seq_op = 00.
- Refresh counter = 0, ref_pend = 0, both sticky flags = 0.
- last_served = DMA, so the CPU wins the first tie.
- RESET asserted mid-access abandons the access immediately: no done pulse is issued and the sequencer is re-reset by the same RESET.

Refresh timer:
- 9-bit counter q increments every cycle.
- At q == REF_INTERVAL−1, q wraps to 0 and issues a tick.
- A tick increments ref_pend. If ref_pend == REF_MAX_PEND, ref_pend is held and ref_overflow is set.
- ref_pend decrements in the cycle seq_start is issued with seq_op = 10.
- Tick and refresh issue in the same cycle: ref_pend is unchanged, and overflow is not set even when at max.

Arbitration (evaluated only in IDLE, one decision per cycle):
- Priority 1: ref_pend == REF_MAX_PEND → refresh (urgent).
- Priority 2: only one of cpu_req/dma_req asserted → that requester.
- Priority 3: both asserted → the requester not equal to last_served; last_served is updated at grant.
- Priority 4: no requests and ref_pend > 0 → refresh (opportunistic).
- Otherwise remain in IDLE.

State machine:
- IDLE → ISSUE when a winner is selected. Owner and seq_op are latched, and the owner's gnt is asserted from ISSUE onward.
- ISSUE: seq_start = 1 for exactly this cycle. → WAIT.
- WAIT: gnt and seq_op are held.
  - seq_done = 1 → DONE.
  - Watchdog counter reaches SEQ_TIMEOUT → set seq_timeout → DONE.
- DONE:
  - Owner's done pulses (none for refresh); gnt is deasserted this cycle. → IDLE.
  - Requests are ignored in DONE; the requester must drop req on the done pulse.
  - A req still high in the next IDLE is treated as a new access.
- seq_done outside WAIT is ignored.
- Deassertion of req during ISSUE/WAIT is ignored; the access completes and done still pulses.
- Minimum access turnaround: IDLE, ISSUE, WAIT ≥ 1 cycle, DONE = 4 cycles.
- At most one gnt is asserted at any time; gnt is 0 in IDLE.

Test Plan:
- Reset then idle 2000 cycles with no req → ticks at cycles 500/1000/1500; each refresh issues seq_start with op = 10; ref_pend returns to 0; seq_done returned 3 cycles after start.
- Hold cpu_req continuously with seq_done never returned (timeout path) and SEQ_TIMEOUT = 64 → seq_timeout set after 64 WAIT cycles; cpu_done pulses; next cpu access is issued.
- cpu_req and dma_req asserted together, re-asserted after each done, for 6 accesses → grant order CPU, DMA, CPU, DMA, CPU, DMA; never two gnts at once.
- cpu_req held back-to-back for 5 × REF_INTERVAL → ref_pend climbs to 4, then refresh preempts at the next IDLE; no overflow as long as refresh issue coincides with or precedes the fifth tick.
- Backlog at 4 with seq_done withheld until a further tick → ref_overflow = 1 and stays 1; ref_pend stays 4.
- RESET asserted during WAIT of a DMA access → next cycle: state IDLE, dma_gnt = 0, no dma_done pulse, ref_pend = 0, q = 0.
